// File: rtl/cam_pkg.sv
// Shared camera-path definitions: default geometry, writer state encoding and
// counter width helpers used by the capture, writer and display-reader blocks.
package cam_pkg;

  localparam int H_RES_DEF = 160;
  localparam int V_RES_DEF = 120;
  localparam int DW_DEF    = 8;
  localparam int AW_DEF    = 15;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_DONE    = 2'd2
  } cam_state_e;

  // Bits needed to hold every value 0..n inclusive.
  function automatic int cnt_width(input int n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

  localparam int COL_W_DEF    = cnt_width(H_RES_DEF);
  localparam int ROW_W_DEF    = cnt_width(V_RES_DEF);
  localparam int FB_DEPTH_DEF = H_RES_DEF * V_RES_DEF;

endpackage

// File: rtl/cam_frame_writer_if.sv
// Frame-buffer write port: the writer drives it (master), the BRAM consumes it (slave).
interface cam_frame_writer_if #(
  parameter int DW = 8,
  parameter int AW = 15
);
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;

  modport master (output wr_en, output wr_addr, output wr_data);
  modport slave  (input  wr_en, input  wr_addr, input  wr_data);
endinterface

// File: rtl/cam_line_counter.sv
// Column/row position tracker with a running line-start address, so the next
// line always begins at a multiple of H_RES regardless of the previous line length.
module cam_line_counter
  import cam_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clr,
  input  logic                        inc,
  input  logic                        eol,
  output logic [cnt_width(H_RES)-1:0] col,
  output logic [cnt_width(V_RES)-1:0] row,
  output logic [AW-1:0]               addr
);

  localparam int COL_W = cnt_width(H_RES);
  localparam int ROW_W = cnt_width(V_RES);

  logic [COL_W-1:0] col_q, col_d, col_base_s;
  logic [ROW_W-1:0] row_q, row_d, row_base_s;
  logic [AW-1:0]    line_q, line_d, line_base_s;
  logic [AW-1:0]    addr_q, addr_d, addr_base_s;

  // clr restarts the frame; a pixel in the same cycle counts from the restarted origin.
  always_comb begin
    col_base_s  = clr ? '0 : col_q;
    row_base_s  = clr ? '0 : row_q;
    line_base_s = clr ? '0 : line_q;
    addr_base_s = clr ? '0 : addr_q;
    col_d       = col_base_s;
    row_d       = row_base_s;
    line_d      = line_base_s;
    addr_d      = addr_base_s;
    if (eol) begin
      col_d  = '0;
      row_d  = row_base_s + 1'b1;
      line_d = line_base_s + AW'(H_RES);
      addr_d = line_base_s + AW'(H_RES);
    end else if (inc) begin
      col_d  = col_base_s + 1'b1;
      addr_d = addr_base_s + 1'b1;
    end else begin
      col_d  = col_base_s;
      addr_d = addr_base_s;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col_q  <= '0;
      row_q  <= '0;
      line_q <= '0;
      addr_q <= '0;
    end else begin
      col_q  <= col_d;
      row_q  <= row_d;
      line_q <= line_d;
      addr_q <= addr_d;
    end
  end

  assign col  = col_q;
  assign row  = row_q;
  assign addr = addr_q;

endmodule

// File: rtl/cam_frame_writer.sv
// Camera frame writer: turns the capture pixel stream into linear frame-buffer
// writes and reports frame completion, restarts and malformed lines.
module cam_frame_writer
  import cam_pkg::*;
#(
  parameter int H_RES = H_RES_DEF,
  parameter int V_RES = V_RES_DEF,
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        arm,
  input  logic                        sof,
  input  logic                        eol,
  input  logic                        px_valid,
  input  logic [DW-1:0]               px_data,
  cam_frame_writer_if.master          wr,
  output logic                        busy,
  output logic                        frame_done,
  output logic                        frame_abort,
  output logic                        line_err,
  output logic [cnt_width(V_RES)-1:0] row
);

  localparam int COL_W = cnt_width(H_RES);
  localparam int ROW_W = cnt_width(V_RES);

  cam_state_e       state_q, state_d;
  logic             wr_en_q, wr_en_d;
  logic [AW-1:0]    wr_addr_q, wr_addr_d;
  logic [DW-1:0]    wr_data_q, wr_data_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             frame_abort_q, frame_abort_d;
  logic             line_err_q, line_err_d;

  logic [COL_W-1:0] col_s;
  logic [ROW_W-1:0] row_s;
  logic [AW-1:0]    addr_s;
  logic             cap_s, entry_s, run_s, room_s;
  logic             accept_s, drop_s, eol_s, short_s, last_s;
  logic [COL_W:0]   col_eff_s;

  cam_line_counter #(
    .H_RES (H_RES),
    .V_RES (V_RES),
    .AW    (AW)
  ) u_line_counter (
    .clk  (clk),
    .rst  (rst),
    .clr  (entry_s),
    .inc  (accept_s),
    .eol  (eol_s),
    .col  (col_s),
    .row  (row_s),
    .addr (addr_s)
  );

  // sof dominates everything in its cycle; eol only counts while a frame runs.
  always_comb begin
    cap_s     = (state_q == ST_CAPTURE);
    entry_s   = sof && arm;
    run_s     = cap_s && !sof;
    room_s    = (col_s < COL_W'(H_RES));
    accept_s  = px_valid && (entry_s || (run_s && room_s));
    drop_s    = px_valid && run_s && !room_s;
    eol_s     = eol && run_s;
    col_eff_s = {1'b0, col_s} + {{COL_W{1'b0}}, accept_s};
    short_s   = eol_s && (col_eff_s != (COL_W+1)'(H_RES));
    last_s    = eol_s && (row_s == ROW_W'(V_RES - 1));

    case (state_q)
      ST_IDLE:    state_d = entry_s ? ST_CAPTURE : ST_IDLE;
      ST_CAPTURE: begin
        if (sof) begin
          state_d = arm ? ST_CAPTURE : ST_IDLE;
        end else if (last_s) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_CAPTURE;
        end
      end
      ST_DONE:    state_d = entry_s ? ST_CAPTURE : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase

    wr_en_d       = accept_s;
    wr_addr_d     = accept_s ? (entry_s ? '0 : addr_s) : wr_addr_q;
    wr_data_d     = accept_s ? px_data : wr_data_q;
    busy_d        = (state_d == ST_CAPTURE);
    frame_done_d  = (state_d == ST_DONE);
    frame_abort_d = sof && cap_s;
    line_err_d    = entry_s ? 1'b0 : (line_err_q | short_s | drop_s);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      wr_en_q       <= 1'b0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      frame_abort_q <= 1'b0;
      line_err_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      wr_en_q       <= wr_en_d;
      wr_addr_q     <= wr_addr_d;
      wr_data_q     <= wr_data_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      frame_abort_q <= frame_abort_d;
      line_err_q    <= line_err_d;
    end
  end

  assign wr.wr_en     = wr_en_q;
  assign wr.wr_addr   = wr_addr_q;
  assign wr.wr_data   = wr_data_q;
  assign busy         = busy_q;
  assign frame_done   = frame_done_q;
  assign frame_abort  = frame_abort_q;
  assign line_err     = line_err_q;
  assign row          = row_s;

endmodule
